// File: rtl/nibble_serial_adder_pkg.sv
// ============================================================================
// adder_pkg: shared constants and FSM state type for the nibble-serial adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The index counter is never narrower than one bit, even when NIB == 1.
  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_serial_adder_rca.sv
// ============================================================================
// RCA_4bit: 4-bit ripple-carry adder stage, purely combinational.
// Revision: 1.0
// ============================================================================
`default_nettype none

module RCA_4bit
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                cout_o
);

  logic [NIBBLE_W:0] w_carry;

  assign w_carry[0] = cin_i;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign sum_o[i]      = a_i[i] ^ b_i[i] ^ w_carry[i];
    assign w_carry[i+1]  = (a_i[i] & b_i[i]) | (w_carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = w_carry[NIBBLE_W];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// nibble_serial_adder: WIDTH-bit add done one nibble per cycle on a single
// RCA_4bit stage. Revision: 1.0
// ============================================================================
`default_nettype none

module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = idx_width(NIB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  state_t                  state_q;
  logic [WIDTH-1:0]        a_q, b_q, sum_sh_q, sum_q;
  logic [WIDTH-1:0]        a_d, b_d, sum_sh_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    carry_q, cout_q, busy_q, done_q;
  logic [NIBBLE_W-1:0]     w_nsum;
  logic                    w_ncout;
  logic [WIDTH+NIBBLE_W-1:0] w_sum_cat;

  RCA_4bit u_stage (
    .a_i    (a_q[NIBBLE_W-1:0]),
    .b_i    (b_q[NIBBLE_W-1:0]),
    .cin_i  (carry_q),
    .sum_o  (w_nsum),
    .cout_o (w_ncout)
  );

  // Concatenate before slicing so the shift also works when WIDTH == 4.
  assign w_sum_cat = {w_nsum, sum_sh_q};
  assign sum_sh_d  = w_sum_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
  assign a_d       = a_q >> NIBBLE_W;
  assign b_d       = b_q >> NIBBLE_W;
  assign idx_d     = idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            carry_q <= cin_i;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sum_sh_q <= sum_sh_d;
          carry_q  <= w_ncout;
          a_q      <= a_d;
          b_q      <= b_d;
          idx_q    <= idx_d;
          if (idx_q == LAST_IDX) begin
            sum_q   <= sum_sh_d;
            cout_q  <= w_ncout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// tb_nibble_serial_adder: directed checks of the 16-bit nibble-serial adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout;
  logic [15:0] sum;

  int total = 0;
  int bad   = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .cin_i   (cin),
    .busy_o  (busy),
    .done_o  (done),
    .sum_o   (sum),
    .cout_o  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after done.
  task automatic do_add(input logic [15:0] ta, input logic [15:0] tb2, input logic tc,
                        input logic [15:0] es, input logic ec, input string tag);
    int lat;
    start = 1'b1; a = ta; b = tb2; cin = tc;
    @(negedge clk);
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
    check({tag, "_busy1"}, busy, 1);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 5);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    @(negedge clk);
    check({tag, "_done_clr"}, {busy, done}, 2'b00);
    check({tag, "_sum_hold"}, sum, es);
  endtask

  initial begin
    int dcnt, t1, t2, cyc;

    repeat (2) @(negedge clk);
    check("rst_outs", {busy, done, cout, sum}, 19'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outs", {busy, done, cout, sum}, 19'h0);

    do_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "basic");
    do_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "ripple");
    do_add(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "cin");
    do_add(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "msb");

    // start in RUN must be ignored
    start = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; a = 16'hAAAA;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ign_done", done, 1);
    check("ign_sum", sum, 16'h0002);
    dcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("ign_no_second", dcnt, 0);

    // back-to-back with start held high
    start = 1'b1; a = 16'h0F0F; b = 16'h0101; cin = 1'b0;
    dcnt = 0; t1 = 0; t2 = 0; cyc = 0;
    while (dcnt < 2 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        dcnt++;
        if (dcnt == 1) begin
          t1 = cyc;
          check("b2b_sum1", {cout, sum}, {1'b0, 16'h1010});
          a = 16'h7FFF; b = 16'h0001;
        end else begin
          t2 = cyc;
          check("b2b_sum2", {cout, sum}, {1'b0, 16'h8000});
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_count", dcnt, 2);
    check("b2b_first_lat", t1, 5);
    check("b2b_spacing", t2 - t1, 5);
    @(negedge clk);

    // reset in cycle 3 aborts
    start = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_outs", {busy, done, cout, sum}, 19'h0);
    dcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    do_add(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
